// File: rtl/uart_rx_8n1.sv
// uart_rx_8n1 : serial receive front end of the 8-bit UART.
// Synchronises rxd, detects start bits, samples eight data bits LSB-first at
// mid-bit, checks the stop bit and delivers each byte with a one-cycle strobe.
// Optional feature macro: UART_RX_PARITY_EN adds a ninth, even-parity bit
// between data bit 7 and the stop bit. Without it the framing is plain 8N1
// and parity_err is tied low.
module uart_rx_8n1 #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    input  logic       rx_enable,
    output logic [7:0] rx_data,
    output logic       rx_ready,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       parity_err
);

    // Last count of a full bit period, and the mid-point of the start bit.
    localparam logic [15:0] LP_LAST = 16'(CLKS_PER_BIT - 32'd1);
    localparam logic [15:0] LP_HALF = 16'((CLKS_PER_BIT / 32'd2) - 32'd1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;
`endif

    // Even parity: the nine received bits must contain an even number of ones.
    function automatic logic f_even_parity_err(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_sync1;
    logic        r_rxs;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;
    logic [2:0]  r_idx;
    logic [2:0]  w_idx_nxt;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_nxt;
    logic [7:0]  r_rx_data;
    logic [7:0]  w_rx_data_nxt;
    logic        r_rx_ready;
    logic        w_rx_ready_nxt;
    logic        r_frame_err;
    logic        w_frame_err_nxt;
    logic        r_parity_err;
    logic        w_parity_err_nxt;
    logic        r_rx_busy;
    logic [15:0] w_cnt_inc;
`ifdef UART_RX_PARITY_EN
    logic        r_par_bit;
    logic        w_par_bit_nxt;
`endif

    // Two-flop synchroniser for the asynchronous serial line, idle high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_rxs   <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_rxs   <= r_sync1;
        end
    end

    // Bit-period counter increment with wrap at the end of a bit.
    always_comb begin
        w_cnt_inc = r_cnt + 16'd1;
        if (r_cnt == LP_LAST) begin
            w_cnt_inc = 16'd0;
        end else begin
            w_cnt_inc = r_cnt + 16'd1;
        end
    end

    // Next-state, datapath and strobe decode for the receive FSM.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = w_cnt_inc;
        w_idx_nxt        = r_idx;
        w_shift_nxt      = r_shift;
        w_rx_data_nxt    = r_rx_data;
        w_rx_ready_nxt   = 1'b0;
        w_frame_err_nxt  = 1'b0;
        w_parity_err_nxt = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_bit_nxt    = r_par_bit;
`endif
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = 16'd0;
                if (rx_enable && !r_rxs) begin
                    w_state_nxt = S_START;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_START: begin
                if (r_cnt == LP_HALF) begin
                    w_cnt_nxt = 16'd0;
                    if (!r_rxs) begin
                        w_state_nxt = S_DATA;
                        w_idx_nxt   = 3'd0;
                    end else begin
                        // Line went back high before mid-bit: a glitch.
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_state_nxt = S_START;
                end
            end
            S_DATA: begin
                if (r_cnt == LP_LAST) begin
                    w_shift_nxt[r_idx] = r_rxs;
                    if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end else begin
                    w_state_nxt = S_DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (r_cnt == LP_LAST) begin
                    w_par_bit_nxt = r_rxs;
                    w_state_nxt   = S_STOP;
                end else begin
                    w_state_nxt = S_PARITY;
                end
            end
`endif
            S_STOP: begin
                if (r_cnt == LP_LAST) begin
                    w_rx_data_nxt = r_shift;
`ifdef UART_RX_PARITY_EN
                    w_parity_err_nxt = f_even_parity_err(r_shift, r_par_bit);
`else
                    w_parity_err_nxt = 1'b0;
`endif
                    if (r_rxs) begin
                        w_rx_ready_nxt = !w_parity_err_nxt;
                        w_state_nxt    = S_IDLE;
                    end else begin
                        // Stop bit low: framing error, wait out a possible break.
                        w_frame_err_nxt = 1'b1;
                        w_state_nxt     = S_BREAK;
                    end
                end else begin
                    w_state_nxt = S_STOP;
                end
            end
            S_BREAK: begin
                w_cnt_nxt = 16'd0;
                if (r_rxs) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_BREAK;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 16'd0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath registers and registered outputs; strobes appear the cycle after the stop sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= 16'd0;
            r_idx        <= 3'd0;
            r_shift      <= 8'h00;
            r_rx_data    <= 8'h00;
            r_rx_ready   <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_rx_busy    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bit    <= 1'b0;
`endif
        end else begin
            r_cnt        <= w_cnt_nxt;
            r_idx        <= w_idx_nxt;
            r_shift      <= w_shift_nxt;
            r_rx_data    <= w_rx_data_nxt;
            r_rx_ready   <= w_rx_ready_nxt;
            r_frame_err  <= w_frame_err_nxt;
            r_parity_err <= w_parity_err_nxt;
            r_rx_busy    <= (w_state_nxt != S_IDLE);
`ifdef UART_RX_PARITY_EN
            r_par_bit    <= w_par_bit_nxt;
`endif
        end
    end

    assign rx_data    = r_rx_data;
    assign rx_ready   = r_rx_ready;
    assign rx_busy    = r_rx_busy;
    assign frame_err  = r_frame_err;
    assign parity_err = r_parity_err;

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Directed testbench for uart_rx_8n1 with CLKS_PER_BIT=16.
// Parity cases are compiled in when UART_RX_PARITY_EN is defined.
module tb_uart_rx_8n1;

    localparam int CPB = 16;

    logic       clk;
    logic       rst_n;
    logic       rxd;
    logic       rx_enable;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_busy;
    logic       frame_err;
    logic       parity_err;

    int n_checks;
    int n_pass;

    // Monitor state, updated on the falling edge.
    int         n_ready;
    int         n_ferr;
    int         n_perr;
    int         n_busy_cyc;
    int         n_busy_at_ready;
    int         n_wide_ready;
    int         n_ready_with_err;
    logic       prev_ready;
    logic [7:0] cap_mem [0:31];

    uart_rx_8n1 #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rxd        (rxd),
        .rx_enable  (rx_enable),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .rx_busy    (rx_busy),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Strobe monitor sampled away from the active edge.
    initial begin
        n_ready          = 0;
        n_ferr           = 0;
        n_perr           = 0;
        n_busy_cyc       = 0;
        n_busy_at_ready  = 0;
        n_wide_ready     = 0;
        n_ready_with_err = 0;
        prev_ready       = 1'b0;
    end

    always @(negedge clk) begin
        prev_ready <= rx_ready;
        if (rx_busy) n_busy_cyc <= n_busy_cyc + 1;
        if (frame_err) n_ferr <= n_ferr + 1;
        if (parity_err) n_perr <= n_perr + 1;
        if (rx_ready) begin
            cap_mem[n_ready[4:0]] <= rx_data;
            n_ready <= n_ready + 1;
            if (rx_busy) n_busy_at_ready <= n_busy_at_ready + 1;
            if (prev_ready) n_wide_ready <= n_wide_ready + 1;
            if (frame_err || parity_err) n_ready_with_err <= n_ready_with_err + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One frame: start, 8 data bits LSB first, [parity], stop. Line left at the stop value.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        rxd = 1'b0;
        wait_cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            wait_cyc(CPB);
        end
`ifdef UART_RX_PARITY_EN
        rxd = par;
        wait_cyc(CPB);
`else
        if (par) begin
            rxd = rxd;
        end
`endif
        rxd = stop;
        wait_cyc(CPB);
    endtask

    int base_rdy;
    int base_ferr;
    int base_busy;

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        rxd       = 1'b1;
        rx_enable = 1'b1;
        wait_cyc(3);

        // Reset state
        chk("rst_data",  {24'd0, rx_data}, 32'h00);
        chk("rst_ready", {31'd0, rx_ready}, 32'd0);
        chk("rst_busy",  {31'd0, rx_busy}, 32'd0);
        chk("rst_ferr",  {31'd0, frame_err}, 32'd0);
        chk("rst_perr",  {31'd0, parity_err}, 32'd0);
        rst_n = 1'b1;
        wait_cyc(5);

        // Basic frame 0xA5
        base_busy = n_busy_cyc;
        send_frame(8'hA5, 1'b0, 1'b1);
        wait_cyc(4);
        chk("a5_nready", n_ready, 1);
        chk("a5_data",   {24'd0, cap_mem[0]}, 32'hA5);
        chk("a5_ferr",   n_ferr, 0);
        chk("a5_busy_in_strobe", n_busy_at_ready, 0);
        chk("a5_busy_seen", (n_busy_cyc > base_busy) ? 32'd1 : 32'd0, 32'd1);

        // 5-cycle glitch: false start
        base_busy = n_busy_cyc;
        rxd = 1'b0;
        wait_cyc(5);
        rxd = 1'b1;
        wait_cyc(30);
        chk("glitch_nready", n_ready, 1);
        chk("glitch_ferr",   n_ferr, 0);
        chk("glitch_data",   {24'd0, rx_data}, 32'hA5);
        chk("glitch_busy",   {31'd0, rx_busy}, 32'd0);
        chk("glitch_busy_seen", (n_busy_cyc > base_busy) ? 32'd1 : 32'd0, 32'd1);

        // 0x3C with stop bit low, line held low 40 more cycles
        send_frame(8'h3C, 1'b0, 1'b0);
        wait_cyc(30);
        chk("brk_busy_hi", {31'd0, rx_busy}, 32'd1);
        wait_cyc(10);
        rxd = 1'b1;
        wait_cyc(5);
        chk("brk_busy_lo", {31'd0, rx_busy}, 32'd0);
        chk("brk_ferr",    n_ferr, 1);
        chk("brk_nready",  n_ready, 1);
        chk("brk_data",    {24'd0, rx_data}, 32'h3C);

        // Receiver disabled: 0x55 ignored entirely
        rx_enable = 1'b0;
        base_busy = n_busy_cyc;
        send_frame(8'h55, 1'b0, 1'b1);
        wait_cyc(10);
        chk("dis_busy",   n_busy_cyc - base_busy, 0);
        chk("dis_nready", n_ready, 1);
        chk("dis_data",   {24'd0, rx_data}, 32'h3C);
        rx_enable = 1'b1;
        wait_cyc(5);

        // 0xF0 with rx_enable dropped during bit 4: frame still completes
        fork
            send_frame(8'hF0, 1'b0, 1'b1);
            begin
                wait_cyc(CPB * 5 + CPB / 2);
                rx_enable = 1'b0;
            end
        join
        wait_cyc(4);
        chk("en_drop_nready", n_ready, 2);
        chk("en_drop_data",   {24'd0, cap_mem[1]}, 32'hF0);
        rx_enable = 1'b1;
        wait_cyc(5);

        // Back-to-back 0x00 then 0xFF, no idle gap
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        wait_cyc(4);
        chk("b2b_nready", n_ready, 4);
        chk("b2b_first",  {24'd0, cap_mem[2]}, 32'h00);
        chk("b2b_second", {24'd0, cap_mem[3]}, 32'hFF);

`ifdef UART_RX_PARITY_EN
        // 0x07 has three ones: even parity bit is 1
        send_frame(8'h07, 1'b0, 1'b1);
        wait_cyc(4);
        chk("par_bad_perr",   n_perr, 1);
        chk("par_bad_nready", n_ready, 4);
        chk("par_bad_data",   {24'd0, rx_data}, 32'h07);
        send_frame(8'h07, 1'b1, 1'b1);
        wait_cyc(4);
        chk("par_ok_nready", n_ready, 5);
        chk("par_ok_data",   {24'd0, cap_mem[4]}, 32'h07);
        chk("par_ok_perr",   n_perr, 1);
`else
        chk("noparity_perr", n_perr, 0);
`endif

        chk("strobe_width", n_wide_ready, 0);
        chk("ready_with_err", n_ready_with_err, 0);

        // Async reset mid-frame: outputs return to reset values at once
        base_rdy  = n_ready;
        base_ferr = n_ferr;
        fork
            send_frame(8'h81, 1'b0, 1'b1);
            begin
                wait_cyc(60);
                chk("mid_busy_pre", {31'd0, rx_busy}, 32'd1);
                #2;
                rst_n = 1'b0;
                #1;
                chk("mid_rst_busy", {31'd0, rx_busy}, 32'd0);
                chk("mid_rst_data", {24'd0, rx_data}, 32'h00);
            end
        join
        rst_n = 1'b1;
        wait_cyc(10);
        chk("mid_rst_nready", n_ready - base_rdy, 0);
        chk("mid_rst_ferr",   n_ferr - base_ferr, 0);
        chk("mid_rst_data2",  {24'd0, rx_data}, 32'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_8n1.md
# uart_rx_8n1

Serial receive front end of the 8-bit UART. Synchronises the asynchronous `rxd` line, detects start bits, samples eight data bits LSB-first at mid-bit, checks the stop bit and delivers each byte with a one-cycle `rx_ready` strobe. It sits directly upstream of the UART controller, which consumes `rx_ready` and drives `rx_enable` back into this block.

## Interface
- `CLKS_PER_BIT`, default 868: clk cycles per bit (100 MHz / 115200 baud). Legal range 4–65535.
- `clk`  input  1  system clock, all state on rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `rxd`  input  1  asynchronous serial line, idle high.
- `rx_enable`  input  1  from controller; new frames accepted only while high.
- `rx_data`  output  8  last received byte, held until next frame completes.
- `rx_ready`  output  1  one-cycle pulse: valid byte on `rx_data`.
- `rx_busy`  output  1  high from start detection until return to IDLE.
- `frame_err`  output  1  one-cycle pulse: stop bit sampled low.
- `parity_err`  output  1  one-cycle pulse: parity mismatch (0 when parity compiled out).

## Operation
- Reset values: `rx_data`=8'h00, `rx_ready`=0, `rx_busy`=0, `frame_err`=0, `parity_err`=0, state IDLE, synchroniser flops=1, counters=0.
- `rxd` passes through a 2-flop synchroniser (reset to 1); all decisions use the synchronised value `rxs`.
- Bit counter: 16 bits, counts 0..CLKS_PER_BIT-1 then wraps to 0. Data index: 3 bits.
- States: IDLE, START, DATA, PARITY (macro only), STOP, BREAK.
- IDLE: if `rx_enable`=1 and `rxs`=0 -> START, counter cleared, `rx_busy`=1. `rx_enable` low holds IDLE regardless of `rxs`.
- START: at counter = CLKS_PER_BIT/2-1 (integer division), sample `rxs`; 0 -> DATA, counter cleared, index 0; 1 -> false start, back to IDLE, no strobe.
- DATA: at counter = CLKS_PER_BIT-1 shift `rxs` into bit [index] of shift register; index 7 -> PARITY (macro) or STOP.
- STOP: at counter = CLKS_PER_BIT-1 sample `rxs`. 1: load `rx_data`, pulse `rx_ready` (unless parity error), -> IDLE. 0: load `rx_data`, pulse `frame_err`, no `rx_ready`, -> BREAK.
- BREAK: wait for `rxs`=1, then -> IDLE. Covers line-break; no strobes generated.
- `rx_enable` deasserted mid-frame does not abort; the frame completes and strobes normally.
- `rx_ready`, `frame_err`, `parity_err` never assert together with `rx_ready`; `frame_err` and `parity_err` may assert together.
- `rx_busy` = (state != IDLE).

## Timing
- Synchroniser latency: 2 cycles from `rxd` edge to `rxs`.
- Start edge to START entry: 3 cycles. Data bit n sampled CLKS_PER_BIT/2 + (n+1)·CLKS_PER_BIT cycles after START entry.
- Strobe outputs are registered: asserted the cycle after the stop-bit sample, exactly one cycle wide; `rx_busy` falls that same cycle.
- Back-to-back frames: a start bit immediately following a good stop bit is detected; IDLE lasts ≥1 cycle.
- Async reset mid-frame: all outputs return to reset values immediately; partial byte discarded.

## Configuration
- `UART_RX_PARITY_EN` defined: 9th bit (even parity) sampled in PARITY state one bit period after data bit 7; STOP follows. Mismatch pulses `parity_err` in the strobe cycle and suppresses `rx_ready`; `rx_data` still loaded.
- Undefined: no PARITY state, 8N1 framing, `parity_err` tied 0.

## Test plan
- CLKS_PER_BIT=16, `rx_enable`=1, send 8'hA5 8N1 -> `rx_data`=8'hA5, single-cycle `rx_ready`, `frame_err`=0, `rx_busy` low in strobe cycle.
- Glitch low on `rxd` for 5 cycles -> returns to IDLE, no strobes, `rx_data` unchanged.
- Send 8'h3C with stop bit 0, line held low 40 cycles -> `frame_err` pulse, no `rx_ready`, `rx_busy` high until line rises.
- `rx_enable`=0, send 8'h55 -> no activity; raise `rx_enable` mid-frame of next byte 8'hF0 sent after de-assert during bit 4 -> 8'hF0 still received.
- Back-to-back 8'h00, 8'hFF with no idle gap -> two `rx_ready` pulses, correct data each.
- With `UART_RX_PARITY_EN`: send 8'h07 with parity bit 0 -> `parity_err` pulse, no `rx_ready`; with parity 1 -> `rx_ready`, `rx_data`=8'h07.
